elev_ctrl: RTL and testbench



---
 rtl/elev_pkg.sv | 31 +++
 rtl/elev_timer.sv | 31 +++
 rtl/elev_ctrl.sv | 175 +++++++++++++++++
 tb/tb_elev_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/elev_pkg.sv
// elev_pkg: shared types and helpers for the elevator controller.
//   NUM_FLOORS   number of floors served by the car
//   floor_t      floor index type (0..3)
//   state_t      controller FSM states
//   calls_ahead  1 when any latched call lies beyond floor f in the given direction
package elev_pkg;

  localparam int NUM_FLOORS = 4;

  typedef logic [1:0] floor_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

  function automatic logic calls_ahead(input logic [NUM_FLOORS-1:0] p,
                                       input floor_t f,
                                       input logic up);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (up && (i > int'(f)) && p[i]) hit = 1'b1;
      if (!up && (i < int'(f)) && p[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/elev_timer.sv
// elev_timer: loadable down-counter that saturates at zero.
//   clk       system clock
//   rst_n     asynchronous active-low reset (count -> 0)
//   load      load load_val this edge (wins over decrement)
//   load_val  value to load
//   cnt       current count
//   zero      1 when cnt == 0
module elev_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/elev_ctrl.sv
// elev_ctrl: 4-floor elevator motion/door controller using a SCAN
// (keep-direction) policy. Feeds floorSel/door to the seven-segment stage.
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   call_req   floor call buttons, bit i = floor i (level or pulse)
//   floorSel   current floor 0..3
//   door       1 = door open
//   moving     1 while in MOVE_UP / MOVE_DOWN
//   dir_up     current or last travel direction, 1 = up
//   pending    latched outstanding calls
//   door_hold  (only with ELEV_DOOR_HOLD_EN) keeps the door open while high
//
// Handshake: there is no valid/ready pair; call_req is a level sampled every
// edge and OR-ed into pending, so a one-cycle pulse is never lost.
// Optional feature macro: ELEV_DOOR_HOLD_EN adds the door_hold input.
// The FSM state is held in the registered enum "state".
module elev_ctrl
  import elev_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] call_req,
  output logic [1:0] floorSel,
  output logic       door,
  output logic       moving,
  output logic       dir_up,
  output logic [3:0] pending
`ifdef ELEV_DOOR_HOLD_EN
  ,
  input  logic       door_hold
`endif
);

  localparam int MAXC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  // Largest value ever loaded is MAXC-1.
  localparam int TW = (MAXC > 2) ? $clog2(MAXC) : 1;
  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);

  state_t                  state, state_d;
  floor_t                  floor_q, floor_d, next_floor;
  logic                    door_q, door_d;
  logic                    moving_q, moving_d;
  logic                    dir_q, dir_d;
  logic [NUM_FLOORS-1:0]   pend_q, pend_d, pend_set, pend_clr;
  logic                    tmr_load, tmr_zero;
  logic [TW-1:0]           tmr_val;
  logic [TW-1:0]           tmr_cnt_unused;
  logic                    hold;

`ifdef ELEV_DOOR_HOLD_EN
  assign hold = door_hold;
`else
  assign hold = 1'b0;
`endif

  elev_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .cnt      (tmr_cnt_unused),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      floor_q  <= '0;
      door_q   <= 1'b0;
      moving_q <= 1'b0;
      dir_q    <= 1'b1;
      pend_q   <= '0;
    end else begin
      state    <= state_d;
      floor_q  <= floor_d;
      door_q   <= door_d;
      moving_q <= moving_d;
      dir_q    <= dir_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    state_d    = state;
    floor_d    = floor_q;
    door_d     = door_q;
    moving_d   = moving_q;
    dir_d      = dir_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    pend_set   = call_req;
    pend_clr   = '0;
    next_floor = floor_q;

    case (state)
      IDLE: begin
        // Decisions look only at the registered pending vector.
        if (pend_q[floor_q]) begin
          state_d           = DOOR_OPEN;
          door_d            = 1'b1;
          pend_clr[floor_q] = 1'b1;
          tmr_load          = 1'b1;
          tmr_val           = DOOR_LOAD;
        end else if (calls_ahead(pend_q, floor_q, dir_q)) begin
          state_d  = dir_q ? MOVE_UP : MOVE_DOWN;
          moving_d = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = TRAVEL_LOAD;
        end else if (calls_ahead(pend_q, floor_q, !dir_q)) begin
          dir_d    = !dir_q;
          state_d  = dir_q ? MOVE_DOWN : MOVE_UP;
          moving_d = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = TRAVEL_LOAD;
        end
      end

      MOVE_UP, MOVE_DOWN: begin
        if (tmr_zero) begin
          // Step one floor, saturating at the shaft ends.
          if (state == MOVE_UP) begin
            next_floor = (floor_q == floor_t'(NUM_FLOORS - 1)) ? floor_q : floor_q + floor_t'(1);
          end else begin
            next_floor = (floor_q == floor_t'(0)) ? floor_q : floor_q - floor_t'(1);
          end
          floor_d = next_floor;
          if (pend_q[next_floor]) begin
            state_d              = DOOR_OPEN;
            door_d               = 1'b1;
            moving_d             = 1'b0;
            pend_clr[next_floor] = 1'b1;
            tmr_load             = 1'b1;
            tmr_val              = DOOR_LOAD;
          end else if (calls_ahead(pend_q, next_floor, dir_q)) begin
            tmr_load = 1'b1;
            tmr_val  = TRAVEL_LOAD;
          end else begin
            state_d  = IDLE;
            moving_d = 1'b0;
          end
        end
      end

      DOOR_OPEN: begin
        // A call for the open floor extends the stop instead of latching.
        pend_set[floor_q] = 1'b0;
        if (call_req[floor_q] || hold) begin
          tmr_load = 1'b1;
          tmr_val  = DOOR_LOAD;
        end else if (tmr_zero) begin
          state_d = IDLE;
          door_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Clear wins over a set of the same bit on the same edge.
    pend_d = (pend_q | pend_set) & ~pend_clr;
  end

  assign floorSel = floor_q;
  assign door     = door_q;
  assign moving   = moving_q;
  assign dir_up   = dir_q;
  assign pending  = pend_q;

endmodule

// File: tb/tb_elev_ctrl.sv
// tb_elev_ctrl: self-checking bench for elev_ctrl (TRAVEL_CYCLES=4, DOOR_CYCLES=3).
// Expected status words {floorSel, door, moving, dir_up, pending} are queued
// with the edge number at which they must hold, and compared on the negedge
// following that edge. Define ELEV_DOOR_HOLD_EN to exercise door_hold.
module tb_elev_ctrl;

  localparam int T = 4;
  localparam int D = 3;
  localparam int W = 9;

  logic       clk;
  logic       rst_n;
  logic [3:0] call_req;
  logic [1:0] floorSel;
  logic       door;
  logic       moving;
  logic       dir_up;
  logic [3:0] pending;
`ifdef ELEV_DOOR_HOLD_EN
  logic       door_hold;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [W-1:0] exp_q[$];
  int           at_q[$];
  string        tag_q[$];

  elev_ctrl #(.TRAVEL_CYCLES(T), .DOOR_CYCLES(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .call_req (call_req),
    .floorSel (floorSel),
    .door     (door),
    .moving   (moving),
    .dir_up   (dir_up),
    .pending  (pending)
`ifdef ELEV_DOOR_HOLD_EN
    ,
    .door_hold(door_hold)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] st(input logic [1:0] f, input logic d, input logic m,
                                      input logic u, input logic [3:0] p);
    return {f, d, m, u, p};
  endfunction

  function automatic logic [W-1:0] status();
    return {floorSel, door, moving, dir_up, pending};
  endfunction

  task automatic expect_at(input string tag, input int at, input logic [W-1:0] v);
    at_q.push_back(at);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit && at_q.size() > 0; i++) @(negedge clk);
    if (at_q.size() != 0) begin
      chk("drain_timeout", W'(at_q.size()), '0);
      at_q.delete();
      exp_q.delete();
      tag_q.delete();
    end
  endtask

  task automatic wait_edge(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    while (at_q.size() > 0 && at_q[0] <= cyc) begin
      void'(at_q.pop_front());
      chk(tag_q.pop_front(), status(), exp_q.pop_front());
    end
  end

  // door and moving must never be high together
  always @(negedge clk) chk("door_moving_excl", W'(door & moving), '0);

  // ---------------- stimulus ----------------
  int e0;
  int dd;

  initial begin
    rst_n    = 1'b0;
    call_req = '0;
`ifdef ELEV_DOOR_HOLD_EN
    door_hold = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_hold", status(), st(2'd0, 1'b0, 1'b0, 1'b1, 4'b0000));
    rst_n = 1'b1;

    // 1: idle, no calls
    @(negedge clk);
    for (int i = 1; i <= 20; i++) expect_at("idle", cyc + i, st(2'd0, 1'b0, 1'b0, 1'b1, 4'b0000));
    drain(40);

    // 2: call floor 2 from floor 0
    @(negedge clk);
    e0 = cyc + 1;
    expect_at("s2_latch",  e0,             st(2'd0, 1'b0, 1'b0, 1'b1, 4'b0100));
    expect_at("s2_start",  e0 + 1,         st(2'd0, 1'b0, 1'b1, 1'b1, 4'b0100));
    expect_at("s2_floor1", e0 + 1 + T,     st(2'd1, 1'b0, 1'b1, 1'b1, 4'b0100));
    expect_at("s2_arrive", e0 + 1 + 2*T,   st(2'd2, 1'b1, 1'b0, 1'b1, 4'b0000));
    expect_at("s2_open",   e0 + 2*T + D,   st(2'd2, 1'b1, 1'b0, 1'b1, 4'b0000));
    expect_at("s2_close",  e0 + 1 + 2*T + D, st(2'd2, 1'b0, 1'b0, 1'b1, 4'b0000));
    call_req = 4'b0100;
    @(negedge clk);
    call_req = '0;
    drain(60);

    // 3: at floor 2 going up, calls for 3 and 0 together
    @(negedge clk);
    e0 = cyc + 1;
    expect_at("s3_latch",  e0,               st(2'd2, 1'b0, 1'b0, 1'b1, 4'b1001));
    expect_at("s3_start",  e0 + 1,           st(2'd2, 1'b0, 1'b1, 1'b1, 4'b1001));
    expect_at("s3_at3",    e0 + 1 + T,       st(2'd3, 1'b1, 1'b0, 1'b1, 4'b0001));
    expect_at("s3_close3", e0 + 1 + T + D,   st(2'd3, 1'b0, 1'b0, 1'b1, 4'b0001));
    expect_at("s3_rev",    e0 + 2 + T + D,   st(2'd3, 1'b0, 1'b1, 1'b0, 4'b0001));
    expect_at("s3_at2",    e0 + 2 + 2*T + D, st(2'd2, 1'b0, 1'b1, 1'b0, 4'b0001));
    expect_at("s3_at1",    e0 + 2 + 3*T + D, st(2'd1, 1'b0, 1'b1, 1'b0, 4'b0001));
    expect_at("s3_at0",    e0 + 2 + 4*T + D, st(2'd0, 1'b1, 1'b0, 1'b0, 4'b0000));
    expect_at("s3_close0", e0 + 2 + 4*T + 2*D, st(2'd0, 1'b0, 1'b0, 1'b0, 4'b0000));
    call_req = 4'b1001;
    @(negedge clk);
    call_req = '0;
    drain(80);

    // 4: door open at floor 1, same-floor call on its 2nd cycle extends it
    @(negedge clk);
    e0 = cyc + 1;
    dd = e0 + 1 + T;
    expect_at("s4_latch",  e0,        st(2'd0, 1'b0, 1'b0, 1'b0, 4'b0010));
    expect_at("s4_flip",   e0 + 1,    st(2'd0, 1'b0, 1'b1, 1'b1, 4'b0010));
    expect_at("s4_open",   dd,        st(2'd1, 1'b1, 1'b0, 1'b1, 4'b0000));
    expect_at("s4_nolat",  dd + 1,    st(2'd1, 1'b1, 1'b0, 1'b1, 4'b0000));
    expect_at("s4_ext",    dd + D,    st(2'd1, 1'b1, 1'b0, 1'b1, 4'b0000));
    expect_at("s4_close",  dd + 1 + D, st(2'd1, 1'b0, 1'b0, 1'b1, 4'b0000));
    call_req = 4'b0010;
    @(negedge clk);
    call_req = '0;
    wait_edge(dd);
    call_req = 4'b0010;
    @(negedge clk);
    call_req = '0;
    drain(60);

    // 5: reset mid-travel between floors 1 and 2
    @(negedge clk);
    e0 = cyc + 1;
    expect_at("s5_start", e0 + 1, st(2'd1, 1'b0, 1'b1, 1'b1, 4'b1001));
    expect_at("s5_mid",   e0 + 3, st(2'd1, 1'b0, 1'b1, 1'b1, 4'b1001));
    call_req = 4'b1001;
    @(negedge clk);
    call_req = '0;
    wait_edge(e0 + 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s5_async_rst", status(), st(2'd0, 1'b0, 1'b0, 1'b1, 4'b0000));
    drain(10);
    @(negedge clk);
    chk("s5_in_rst", status(), st(2'd0, 1'b0, 1'b0, 1'b1, 4'b0000));
    rst_n = 1'b1;
    expect_at("s5_after1", cyc + 1, st(2'd0, 1'b0, 1'b0, 1'b1, 4'b0000));
    expect_at("s5_after3", cyc + 3, st(2'd0, 1'b0, 1'b0, 1'b1, 4'b0000));
    drain(20);

    // 7: call for the current floor held two cycles; clear beats set
    @(negedge clk);
    e0 = cyc + 1;
    expect_at("s7_latch", e0,         st(2'd0, 1'b0, 1'b0, 1'b1, 4'b0001));
    expect_at("s7_open",  e0 + 1,     st(2'd0, 1'b1, 1'b0, 1'b1, 4'b0000));
    expect_at("s7_last",  e0 + D,     st(2'd0, 1'b1, 1'b0, 1'b1, 4'b0000));
    expect_at("s7_close", e0 + 1 + D, st(2'd0, 1'b0, 1'b0, 1'b1, 4'b0000));
    call_req = 4'b0001;
    repeat (2) @(negedge clk);
    call_req = '0;
    drain(30);

`ifdef ELEV_DOOR_HOLD_EN
    // 6: door_hold for 10 cycles during DOOR_OPEN
    @(negedge clk);
    e0 = cyc + 1;
    dd = e0 + 1;
    expect_at("s6_latch", e0, st(2'd0, 1'b0, 1'b0, 1'b1, 4'b0001));
    for (int i = 0; i <= 10 + D - 1; i++)
      expect_at("s6_held", dd + i, st(2'd0, 1'b1, 1'b0, 1'b1, 4'b0000));
    expect_at("s6_close", dd + 10 + D, st(2'd0, 1'b0, 1'b0, 1'b1, 4'b0000));
    call_req = 4'b0001;
    @(negedge clk);
    call_req = '0;
    wait_edge(dd);
    door_hold = 1'b1;
    repeat (10) @(negedge clk);
    door_hold = 1'b0;
    drain(40);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
